adder_target: RTL and testbench

- Branch/jump target adder for the RV32 single-cycle core: PCTarget = PC + ImmExt.
- Sum is combinational, so the core's same-cycle next-PC mux can use it.
- A registered copy with valid, wrap and misalignment flags feeds trace/debug and later pipelined variants.
- Sits beside the PC+4 adder, ahead of the PCSrc mux.

---
 rtl/adder_target.sv | 99 +++++++++
 tb/tb_adder_target.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/adder_target.sv
// Purpose : branch/jump target adder, PCTarget = PC + ImmExt, with a registered trace copy.
// Latency : PCTarget is combinational (0 cycles); PCTarget_q and flags follow in_valid by 1 cycle.
// Backpr. : none; every in_valid cycle is captured, back-to-back, with no stall.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   PC, ImmExt        current PC and sign-extended immediate (two's complement)
//   in_valid          operands valid for the registered stage
//   PCTarget          combinational (PC + ImmExt) mod 2^XLEN
//   PCTarget_q        registered PCTarget
//   out_valid         PCTarget_q and flags hold a fresh capture this cycle
//   wrap_q            registered address-space wrap flag
//   misaligned_q      registered target-misaligned flag
//
// Build option: define ADDER_TARGET_MISALIGN_CHECK_EN to compute misaligned_q
// from IALIGN (32 or 16). Without it misaligned_q is tied to 0 and no
// alignment logic exists.

module adder_target #(
    parameter int XLEN   = 32,
    parameter int IALIGN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] ImmExt,
    input  logic            in_valid,
    output logic [XLEN-1:0] PCTarget,
    output logic [XLEN-1:0] PCTarget_q,
    output logic            out_valid,
    output logic            wrap_q,
    output logic            misaligned_q
);

    // Only 32-bit and 16-bit (compressed) instruction alignment exist.
    if (IALIGN != 32 && IALIGN != 16) begin : g_bad_ialign
        $error("adder_target: IALIGN must be 32 or 16");
    end

    // One extra bit to recover the carry out of the unsigned add.
    logic [XLEN:0] sum_ext;
    logic          carry;
    logic          imm_neg;
    logic          imm_nz;
    logic          wrap;

    assign sum_ext  = {1'b0, PC} + {1'b0, ImmExt};
    assign PCTarget = sum_ext[XLEN-1:0];
    assign carry    = sum_ext[XLEN];
    assign imm_neg  = ImmExt[XLEN-1];
    assign imm_nz   = |ImmExt;

    // A positive offset wraps past the top when the add carries out.
    // A negative offset is an add of 2^XLEN - |imm|, so it stays in range
    // exactly when it carries; no carry with a nonzero imm means we went
    // below address zero.
    assign wrap = imm_neg ? (~carry & imm_nz) : carry;

    logic misaligned;

`ifdef ADDER_TARGET_MISALIGN_CHECK_EN
    if (IALIGN == 16) begin : g_align16
        assign misaligned = PCTarget[0];
    end else begin : g_align32
        assign misaligned = |PCTarget[1:0];
    end
`else
    assign misaligned = 1'b0;
`endif

    // Registered stage: reset dominates in_valid; without in_valid the
    // data and flags hold while out_valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            PCTarget_q <= '0;
            out_valid  <= 1'b0;
            wrap_q     <= 1'b0;
        end else if (in_valid) begin
            PCTarget_q <= PCTarget;
            out_valid  <= 1'b1;
            wrap_q     <= wrap;
        end else begin
            out_valid  <= 1'b0;
        end
    end

`ifdef ADDER_TARGET_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misaligned_q <= 1'b0;
        end else if (in_valid) begin
            misaligned_q <= misaligned;
        end
    end
`else
    assign misaligned_q = misaligned;
`endif

endmodule

// File: tb/tb_adder_target.sv
module tb_adder_target;

    localparam int XLEN   = 32;
    localparam int IALIGN = 32;

    logic            clk;
    logic            rst;
    logic [XLEN-1:0] PC;
    logic [XLEN-1:0] ImmExt;
    logic            in_valid;
    logic [XLEN-1:0] PCTarget;
    logic [XLEN-1:0] PCTarget_q;
    logic            out_valid;
    logic            wrap_q;
    logic            misaligned_q;

    adder_target #(.XLEN(XLEN), .IALIGN(IALIGN)) dut (
        .clk          (clk),
        .rst          (rst),
        .PC           (PC),
        .ImmExt       (ImmExt),
        .in_valid     (in_valid),
        .PCTarget     (PCTarget),
        .PCTarget_q   (PCTarget_q),
        .out_valid    (out_valid),
        .wrap_q       (wrap_q),
        .misaligned_q (misaligned_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] t;
        logic            w;
        logic            m;
    } exp_t;

    exp_t sb[$];
    exp_t held;
    int   total = 0;
    int   bad   = 0;

    // Reference model: signed arithmetic in a wide integer, independent of carry logic.
    function automatic exp_t model(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm);
        exp_t    e;
        longint  s;
        s   = longint'({32'd0, pc}) + longint'($signed(imm));
        e.t = pc + imm;
        e.w = (s < 0) || (s >= 64'sh1_0000_0000);
`ifdef ADDER_TARGET_MISALIGN_CHECK_EN
        e.m = (IALIGN == 16) ? e.t[0] : (e.t[1:0] != 2'b00);
`else
        e.m = 1'b0;
`endif
        return e;
    endfunction

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One cycle: drive at negedge, check comb sum, then check the registered
    // stage just after the following rising edge against the scoreboard.
    task automatic step(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                        input bit v, input bit r, input string tag);
        exp_t e;
        bit   expect_vld;
        @(negedge clk);
        PC = pc; ImmExt = imm; in_valid = v; rst = r;
        #1;
        e = model(pc, imm);
        chk({tag, ".comb"}, PCTarget, e.t);
        if (v && !r) sb.push_back(e);
        @(posedge clk);
        #1;
        if (r) begin
            held.t = '0; held.w = 1'b0; held.m = 1'b0;
        end
        expect_vld = (sb.size() != 0);
        chk({tag, ".vld"}, {31'd0, out_valid}, {31'd0, expect_vld});
        if (expect_vld) held = sb.pop_front();
        chk({tag, ".q"},    PCTarget_q,           held.t);
        chk({tag, ".wrap"}, {31'd0, wrap_q},       {31'd0, held.w});
        chk({tag, ".mis"},  {31'd0, misaligned_q}, {31'd0, held.m});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        held.t = '0; held.w = 1'b0; held.m = 1'b0;
        rst = 1'b1; in_valid = 1'b0; PC = '0; ImmExt = '0;
        repeat (2) @(posedge clk);

        // Reset state, with comb path live during reset.
        step(32'd0, 32'd4, 1'b0, 1'b1, "reset");

        // Directed cases.
        step(32'd0,          32'd4,          1'b1, 1'b0, "pc0_imm4");
        step(32'd10,         32'd20,         1'b1, 1'b0, "pc10_imm20");
        step(32'd100,        32'hFFFF_FFCE,  1'b1, 1'b0, "neg_imm");
        step(32'hFFFF_FFFC,  32'd8,          1'b1, 1'b0, "wrap_up");
        step(32'd4,          32'hFFFF_FFF8,  1'b1, 1'b0, "wrap_down");
        step(32'd0,          32'd0,          1'b1, 1'b0, "zero_imm");
        step(32'h8000_0000,  32'h8000_0000,  1'b1, 1'b0, "carry_exact");
        step(32'd2,          32'hFFFF_FFFE,  1'b1, 1'b0, "neg_to_zero");
        step(32'd1,          32'hFFFF_FFFE,  1'b1, 1'b0, "neg_below_zero");

        // Reset dominates in_valid; comb still shows 0x1010.
        step(32'h0000_1000,  32'h10,         1'b1, 1'b1, "rst_vs_valid");

        // Pulse then idle with changing inputs: data holds, valid drops.
        step(32'h0000_2000,  32'h6,          1'b1, 1'b0, "pulse");
        step(32'h1234_5678,  32'h1111,       1'b0, 1'b0, "hold1");
        step(32'hDEAD_BEEF,  32'hFFFF_0000,  1'b0, 1'b0, "hold2");

        // Back-to-back random captures with occasional gaps.
        for (int i = 0; i < 40; i++) begin
            logic [XLEN-1:0] p;
            logic [XLEN-1:0] m;
            bit              v;
            p = $urandom();
            m = $urandom();
            if (i % 4 == 1) m = {{20{m[11]}}, m[11:0]};
            v = (i < 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
            step(p, m, v, 1'b0, "rand");
        end

        // Final reset clears everything.
        step(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, "final_rst");

        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
